demux_stream_1x2: RTL

//  Registered 1-to-2 stream demultiplexer with valid/ready handshake on all ports.

---
 rtl/demux_stream_pkg.sv | 9 +
 rtl/demux_stream_1x2_stage.sv | 55 +++++
 rtl/demux_stream_1x2.sv | 78 +++++++
 3 files changed

// File: rtl/demux_stream_pkg.sv
// Shared select encodings and output-stage state type for demux_stream_1x2.
package demux_stream_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic {STAGE_EMPTY, STAGE_FULL} stage_state_t;

endpackage

// File: rtl/demux_stream_1x2_stage.sv
// One-entry valid/ready register stage (stream_reg_stage); accepts a beat
// whenever empty or draining in the same cycle, so pass-through has no bubble.
module stream_reg_stage
  import demux_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  stage_state_t     r_state;
  stage_state_t     w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             w_load;
  logic             w_drain;

  always_comb begin
    w_drain      = (r_state == STAGE_FULL) && i_ready;
    o_ready      = (r_state == STAGE_EMPTY) || i_ready;
    w_load       = i_valid && o_ready;
    w_state_next = r_state;
    case (r_state)
      STAGE_EMPTY: if (w_load) w_state_next = STAGE_FULL;
      STAGE_FULL:  if (w_drain && !w_load) w_state_next = STAGE_EMPTY;
      default:     w_state_next = STAGE_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STAGE_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = (r_state == STAGE_FULL);
  assign o_data  = r_data;

endmodule

// File: rtl/demux_stream_1x2.sv
// Registered 1-to-2 stream demultiplexer; optional per-output beat counters
// enabled by defining DEMUX_STREAM_COUNT_EN.
module demux_stream_1x2
  import demux_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [WIDTH-1:0]     out1_data
`ifdef DEMUX_STREAM_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] out0_count,
  output logic [CNT_WIDTH-1:0] out1_count
`endif
);

  logic w_valid0;
  logic w_valid1;
  logic w_ready0;
  logic w_ready1;

  // Each stage only sees in_valid when selected, so its own load equals loadN.
  assign w_valid0 = in_valid && (in_sel == SEL_OUT0);
  assign w_valid1 = in_valid && (in_sel == SEL_OUT1);
  assign in_ready = (in_sel == SEL_OUT1) ? w_ready1 : w_ready0;

  stream_reg_stage #(.WIDTH(WIDTH)) u_stage0 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_valid0),
    .o_ready (w_ready0),
    .i_data  (in_data),
    .o_valid (out0_valid),
    .i_ready (out0_ready),
    .o_data  (out0_data)
  );

  stream_reg_stage #(.WIDTH(WIDTH)) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_valid1),
    .o_ready (w_ready1),
    .i_data  (in_data),
    .o_valid (out1_valid),
    .i_ready (out1_ready),
    .o_data  (out1_data)
  );

`ifdef DEMUX_STREAM_COUNT_EN
  logic [CNT_WIDTH-1:0] r_out0_count;
  logic [CNT_WIDTH-1:0] r_out1_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0_count <= '0;
      r_out1_count <= '0;
    end else begin
      if (out0_valid && out0_ready) r_out0_count <= r_out0_count + CNT_WIDTH'(1);
      if (out1_valid && out1_ready) r_out1_count <= r_out1_count + CNT_WIDTH'(1);
    end
  end

  assign out0_count = r_out0_count;
  assign out1_count = r_out1_count;
`endif

endmodule
